// File: rtl/polaris_pkg.sv
// ---------------------------------------------------------------------------
// polaris_pkg
// Shared definitions for the 64-bit processor data bus to 16-bit Wishbone
// bridge: transfer-size encodings, bridge FSM state encodings and two small
// helpers that decode a request's size into alignment and beat count.
// Ports: none (package).
// ---------------------------------------------------------------------------
package polaris_pkg;

  localparam int ADR_W  = 64;
  localparam int DAT_W  = 64;
  localparam int BUS_W  = 16;
  localparam int NBEATS = DAT_W / BUS_W;

  // Transfer size as presented by the processor D master.
  typedef enum logic [1:0] {
    SIZ_BYTE  = 2'd0,
    SIZ_HALF  = 2'd1,
    SIZ_WORD  = 2'd2,
    SIZ_DWORD = 2'd3
  } siz_e;

  // Bridge sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A request is misaligned when its address is not a multiple of its size.
  // Bytes can never be misaligned.
  function automatic logic misaligned(input logic [1:0] siz,
                                      input logic [2:0] adr_lo);
    logic res;
    case (siz)
      SIZ_HALF:  res = adr_lo[0];
      SIZ_WORD:  res = |adr_lo[1:0];
      SIZ_DWORD: res = |adr_lo;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  // Index of the final 16-bit beat for a given size (beats - 1).
  function automatic logic [1:0] last_beat(input logic [1:0] siz);
    logic [1:0] res;
    case (siz)
      SIZ_WORD:  res = 2'd1;
      SIZ_DWORD: res = 2'd3;
      default:   res = 2'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dbus_bridge16_if.sv
// ---------------------------------------------------------------------------
// dbus_bridge16_if
// 16-bit Wishbone-style bus between the bridge (master) and a bus target
// (slave).
// Signals:
//   wb_cyc_o  cycle in progress            (master -> slave)
//   wb_stb_o  beat strobe                  (master -> slave)
//   wb_we_o   write enable                 (master -> slave)
//   wb_adr_o  64-bit byte address, bit0=0  (master -> slave)
//   wb_sel_o  byte-lane select, lane0=even (master -> slave)
//   wb_dat_o  16-bit write data            (master -> slave)
//   wb_ack_i  beat acknowledge             (slave -> master)
//   wb_dat_i  16-bit read data             (slave -> master)
// ---------------------------------------------------------------------------
interface dbus_bridge16_if;
  import polaris_pkg::*;

  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [ADR_W-1:0] wb_adr_o;
  logic [1:0]       wb_sel_o;
  logic [BUS_W-1:0] wb_dat_o;
  logic             wb_ack_i;
  logic [BUS_W-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_dat_i
  );

endinterface

// File: rtl/dbus_bridge16_dext.sv
// ---------------------------------------------------------------------------
// dext
// Purely combinational sign/zero extension of assembled read data to 64 bits.
// Ports:
//   i_raw    64-bit raw data, valid bits right-justified
//   i_siz    transfer size (byte/half/word/dword)
//   i_signed 1 = sign-extend, 0 = zero-extend (ignored for dword)
//   o_ext    64-bit extended result
// ---------------------------------------------------------------------------
module dext
  import polaris_pkg::*;
(
  input  logic [DAT_W-1:0] i_raw,
  input  logic [1:0]       i_siz,
  input  logic             i_signed,
  output logic [DAT_W-1:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_siz)
      SIZ_BYTE:  o_ext = {{56{i_signed & i_raw[7]}},  i_raw[7:0]};
      SIZ_HALF:  o_ext = {{48{i_signed & i_raw[15]}}, i_raw[15:0]};
      SIZ_WORD:  o_ext = {{32{i_signed & i_raw[31]}}, i_raw[31:0]};
      default:   o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/dbus_bridge16.sv
// ---------------------------------------------------------------------------
// dbus_bridge16
// Bridges a 64-bit processor data port onto a 16-bit Wishbone-style bus.
// A request is latched in IDLE, split into 1/2/4 16-bit beats in BUS with
// cyc held continuously, and completed with a single-cycle dack_o in DONE.
// Misaligned requests skip the bus and complete with derr_o.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   dcyc_i, dstb_i          processor request qualifiers
//   dwe_i, dsiz_i,dsigned_i write enable, size, signed load
//   dadr_i, dwdat_i         64-bit address, 64-bit write data
//   dack_o                  completion strobe (one cycle)
//   derr_o                  misalignment strobe (with dack_o)
//   drdat_o                 extended read data (valid with dack_o)
//   wb                      16-bit bus, master side
// ---------------------------------------------------------------------------
module dbus_bridge16
  import polaris_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dcyc_i,
  input  logic              dstb_i,
  input  logic              dwe_i,
  input  logic [1:0]        dsiz_i,
  input  logic              dsigned_i,
  input  logic [ADR_W-1:0]  dadr_i,
  input  logic [DAT_W-1:0]  dwdat_i,
  output logic              dack_o,
  output logic [DAT_W-1:0]  drdat_o,
  output logic              derr_o,
  dbus_bridge16_if.master   wb
);

  // Latched request and sequencer state.
  state_e           r_state;
  logic             r_we;
  logic [1:0]       r_siz;
  logic             r_signed;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_wdat;
  logic [1:0]       r_beat;

  state_e           w_state_next;
  logic             w_req;
  logic             w_bus;
  logic             w_done;
  logic             w_last;
  logic             w_beat_ack;
  logic             w_err;
  logic [ADR_W-1:0] w_adr_base;
  logic [3:0][BUS_W-1:0] w_rbuf;
  logic [7:0]       w_byte;
  logic [DAT_W-1:0] w_raw;
  logic [DAT_W-1:0] w_ext;

  assign w_req      = dcyc_i & dstb_i;
  assign w_bus      = (r_state == BUS);
  assign w_done     = (r_state == DONE);
  assign w_last     = (r_beat == last_beat(r_siz));
  assign w_beat_ack = w_bus & wb.wb_ack_i;
  // Error flag is re-derived from the latched request rather than stored.
  assign w_err      = misaligned(r_siz, r_adr[2:0]);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = misaligned(dsiz_i, dadr_i[2:0]) ? DONE : BUS;
        end
      end
      BUS: begin
        if (wb.wb_ack_i && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request latch and beat counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_we     <= 1'b0;
      r_siz    <= 2'd0;
      r_signed <= 1'b0;
      r_adr    <= '0;
      r_wdat   <= '0;
    end else if ((r_state == IDLE) && w_req) begin
      r_we     <= dwe_i;
      r_siz    <= dsiz_i;
      r_signed <= dsigned_i;
      r_adr    <= dadr_i;
      r_wdat   <= dwdat_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_beat <= 2'd0;
    end else if ((r_state == IDLE) && w_req) begin
      r_beat <= 2'd0;
    end else if (w_beat_ack) begin
      // Wraps to 0 after the fourth dword beat; unused once in DONE.
      r_beat <= r_beat + 2'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Read buffer: one 16-bit register per beat slot
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_rbuf
      logic [BUS_W-1:0] r_half;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_half <= '0;
        end else if (w_beat_ack && (r_beat == 2'(gi))) begin
          r_half <= wb.wb_dat_i;
        end
      end

      assign w_rbuf[gi] = r_half;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Bus-side outputs: all forced to zero outside BUS
  // -------------------------------------------------------------------------
  assign w_adr_base  = {r_adr[ADR_W-1:1], 1'b0};

  assign wb.wb_cyc_o = w_bus;
  assign wb.wb_stb_o = w_bus;
  assign wb.wb_we_o  = w_bus & r_we;
  assign wb.wb_adr_o = w_bus ? (w_adr_base + {61'd0, r_beat, 1'b0}) : '0;

  always_comb begin
    wb.wb_sel_o = 2'b00;
    if (w_bus) begin
      if (r_siz == SIZ_BYTE) begin
        wb.wb_sel_o = r_adr[0] ? 2'b10 : 2'b01;
      end else begin
        wb.wb_sel_o = 2'b11;
      end
    end
  end

  always_comb begin
    wb.wb_dat_o = '0;
    if (w_bus && r_we) begin
      if (r_siz == SIZ_BYTE) begin
        // Byte is replicated on both lanes; sel picks the live one.
        wb.wb_dat_o = {2{r_wdat[7:0]}};
      end else begin
        wb.wb_dat_o = r_wdat[{r_beat, 4'b0000} +: BUS_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // CPU-side completion
  // -------------------------------------------------------------------------
  assign w_byte = r_adr[0] ? w_rbuf[0][15:8] : w_rbuf[0][7:0];

  always_comb begin
    w_raw = w_rbuf;
    case (r_siz)
      SIZ_BYTE: w_raw = {56'd0, w_byte};
      SIZ_HALF: w_raw = {48'd0, w_rbuf[0]};
      SIZ_WORD: w_raw = {32'd0, w_rbuf[1], w_rbuf[0]};
      default:  w_raw = w_rbuf;
    endcase
  end

  dext u_dext (
    .i_raw    (w_raw),
    .i_siz    (r_siz),
    .i_signed (r_signed),
    .o_ext    (w_ext)
  );

  assign dack_o  = w_done;
  assign derr_o  = w_done & w_err;
  assign drdat_o = (w_done && !r_we && !w_err) ? w_ext : '0;

endmodule

// File: doc/dbus_bridge16.md
DBUS_BRIDGE16 -- requirements
Module: dbus_bridge16

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have CPU-side inputs: dcyc_i (1), dstb_i (1), dwe_i (1), dsiz_i (2), dsigned_i (1), dadr_i (64), dwdat_i (64) -- write data from the processor D master.
REQ-004 SHALL have CPU-side outputs: dack_o (1, completion strobe), drdat_o (64, extended read data), derr_o (1, misalignment strobe).
REQ-005 SHALL have bus-side outputs: wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (64, bit0 always 0), wb_sel_o (2, byte lanes), wb_dat_o (16).
REQ-006 SHALL have bus-side inputs: wb_ack_i (1), wb_dat_i (16).
REQ-007 Size encoding SHALL be 0=byte, 1=half, 2=word, 3=dword; byte lanes little-endian, lane0 = even address.

Function
REQ-008 SHALL implement FSM states IDLE, BUS, DONE.
REQ-009 IDLE: dcyc_i&dstb_i sampled high at an edge SHALL latch dwe_i, dsiz_i, dsigned_i, dadr_i, dwdat_i and clear beat counter.
REQ-010 Misalignment (half: adr[0]!=0; word: adr[1:0]!=0; dword: adr[2:0]!=0) SHALL go IDLE->DONE with no bus cycle, derr_o=1 and drdat_o=0 during DONE.
REQ-011 Aligned request SHALL go IDLE->BUS; beats = 1 (byte, half), 2 (word), 4 (dword).
REQ-012 BUS: wb_cyc_o=wb_stb_o=1 every cycle; wb_we_o = latched dwe; wb_adr_o = {adr[63:1],0} + 2*beat.
REQ-013 wb_sel_o SHALL be 2'b11 for half/word/dword; for byte, 2'b01 if adr[0]=0 else 2'b10.
REQ-014 wb_dat_o SHALL be dwdat[16*beat+15:16*beat]; for byte, {dwdat[7:0],dwdat[7:0]}; wb_dat_o=0 when not writing.
REQ-015 Each BUS cycle with wb_ack_i=1 SHALL capture wb_dat_i into read-buffer halfword [beat] and increment beat; ack in the same cycle stb rises SHALL count (1-cycle minimum per beat).
REQ-016 wb_cyc_o SHALL stay high between beats; ack on last beat SHALL go BUS->DONE and drop cyc/stb next cycle.
REQ-017 DONE SHALL last exactly one cycle: dack_o=1, then ->IDLE; no request accepted in DONE.
REQ-018 drdat_o in DONE (reads): byte = selected lane, half = beat0, word = beats1:0, dword = beats3:0; byte/half/word sign-extended to 64 if dsigned else zero-extended; dword unmodified.
REQ-019 drdat_o SHALL be 0 outside DONE and for writes.
REQ-020 Latency, zero-wait bus: request sampled edge N, first stb cycle N+1, dack_o in cycle N+1+beats.
REQ-021 dstb_i/dcyc_i falling during BUS SHALL be ignored; transfer completes.
REQ-022 wb_ack_i outside BUS SHALL be ignored.
REQ-023 dsigned_i with dsiz=3 SHALL have no effect.

Reset
REQ-024 reset_i high SHALL force IDLE, beat=0, read buffer=0 immediately, independent of clk_i.
REQ-025 During and after reset all outputs SHALL be 0 (wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, dack_o, derr_o, drdat_o).
REQ-026 Reset mid-transfer SHALL abandon it with no dack_o; the first request after release starts at beat 0.

Structure
REQ-027 Size encodings (SIZ_BYTE..SIZ_DWORD) and FSM state encodings SHALL live in shared package polaris_pkg.
REQ-028 Sign/zero extension SHALL be one combinational sub-module, dext (inputs: 64-bit raw, size, signed).
REQ-029 All registers SHALL be in dbus_bridge16; outputs derived combinationally from state and latched request only.

Verification
REQ-030 Byte read adr=0x1001, signed, wb_dat_i=0x80AA, ack immediate -> wb_sel_o=2'b10, one beat, dack_o at N+2, drdat_o=0xFFFF_FFFF_FFFF_FF80.
REQ-031 Dword write adr=0x2000, data=0x1122_3344_5566_7788, ack after 2 wait cycles per beat -> wb_adr_o 0x2000/2/4/6, wb_dat_o 0x7788/0x5566/0x3344/0x1122, cyc continuous, one dack_o.
REQ-032 Word read adr=0x3004, unsigned, beats 0x5678,0x9ABC -> drdat_o=0x0000_0000_9ABC_5678.
REQ-033 Half read adr=0x4001 -> no wb_cyc_o, derr_o=dack_o=1 at N+1, drdat_o=0.
REQ-034 reset_i asserted during beat 2 of dword read -> cyc/stb low immediately, no dack_o; next byte read completes normally.
REQ-035 Stray wb_ack_i in IDLE, then dstb_i dropped mid-word-write -> no state change, then write completes both beats.
